// File: rtl/path_history_repair.sv
// Speculative/architectural path-history keeper with an in-order checkpoint FIFO.
// A resolve that disagrees with its checkpoint restores the history and pulses a repair.
module path_history_repair #(
    parameter int HIST_W = 12,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic              pred_taken,
    output logic              pred_ready,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic [HIST_W-1:0] spec_hist,
    output logic [HIST_W-1:0] arch_hist,
    output logic              repair_valid,
    output logic [HIST_W-1:0] repair_hist,
    output logic [PTR_W:0]    occupancy,
    output logic              err_underflow
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

    state_t             r_state;
    logic [HIST_W-1:0]  r_spec_hist;
    logic [HIST_W-1:0]  r_arch_hist;
    logic [HIST_W-1:0]  r_repair_hist;
    logic               r_repair_valid;
    logic               r_err_underflow;
    logic [PTR_W:0]     r_occ;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;

    // Checkpoint = {predicted dir, history[HIST_W-1:1]}; the history LSB would be
    // shifted out on replay anyway, so it is never stored.
    logic [HIST_W-1:0]  r_fifo [DEPTH];

    logic               w_accept;
    logic               w_pop;
    logic               w_head_pred;
    logic [HIST_W-2:0]  w_head_hist;
    logic               w_mispredict;
    logic               w_push;
    logic [HIST_W-1:0]  w_repaired;

    assign pred_ready   = (r_state == ST_RUN) && (r_occ != OCC_FULL);
    assign w_accept     = pred_valid && pred_ready;
    assign w_pop        = resolve_valid && (r_occ != '0);
    assign {w_head_pred, w_head_hist} = r_fifo[r_rd_ptr];
    assign w_mispredict = w_pop && (resolve_taken != w_head_pred);
    assign w_push       = w_accept && !w_mispredict;
    assign w_repaired   = {resolve_taken, w_head_hist};

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {pred_taken, r_spec_hist[HIST_W-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_RUN;
            r_spec_hist     <= '0;
            r_arch_hist     <= '0;
            r_repair_hist   <= '0;
            r_repair_valid  <= 1'b0;
            r_err_underflow <= 1'b0;
            r_occ           <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
        end else begin
            if (w_pop) begin
                r_arch_hist <= {resolve_taken, r_arch_hist[HIST_W-1:1]};
            end
            if (resolve_valid && (r_occ == '0)) begin
                r_err_underflow <= 1'b1;
            end

            // A mispredict squashes everything younger, including a same-cycle prediction.
            if (w_mispredict) begin
                r_spec_hist    <= w_repaired;
                r_repair_hist  <= w_repaired;
                r_repair_valid <= 1'b1;
                r_state        <= ST_RECOVER;
                r_occ          <= '0;
                r_wr_ptr       <= '0;
                r_rd_ptr       <= '0;
            end else begin
                r_repair_valid <= 1'b0;
                r_state        <= ST_RUN;
                if (w_push) begin
                    r_spec_hist <= {pred_taken, r_spec_hist[HIST_W-1:1]};
                    r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + (PTR_W+1)'(1);
                    2'b01:   r_occ <= r_occ - (PTR_W+1)'(1);
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

    assign spec_hist     = r_spec_hist;
    assign arch_hist     = r_arch_hist;
    assign repair_valid  = r_repair_valid;
    assign repair_hist   = r_repair_hist;
    assign occupancy     = r_occ;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_path_history_repair.sv
// Scoreboard bench for path_history_repair: directed vectors push expected state,
// a negedge monitor pops and compares one transaction per cycle.
module tb_path_history_repair;

    logic        clock;
    logic        reset;
    logic        pred_valid;
    logic        pred_taken;
    logic        pred_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [11:0] spec_hist;
    logic [11:0] arch_hist;
    logic        repair_valid;
    logic [11:0] repair_hist;
    logic [3:0]  occupancy;
    logic        err_underflow;

    path_history_repair #(.HIST_W(12), .DEPTH(8), .PTR_W(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .spec_hist     (spec_hist),
        .arch_hist     (arch_hist),
        .repair_valid  (repair_valid),
        .repair_hist   (repair_hist),
        .occupancy     (occupancy),
        .err_underflow (err_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       nm;
        int          c;
        logic [11:0] s;
        logic [11:0] a;
        logic [3:0]  o;
        logic        rv;
        logic        rdy;
        logic        err;
        logic [11:0] rh;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endfunction

    // Monitor: compares every expectation scheduled for the current cycle.
    exp_t e;
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            $display("cyc %0d %-8s spec=%h arch=%h occ=%0d rv=%b rdy=%b err=%b rh=%h",
                     cyc, e.nm, spec_hist, arch_hist, occupancy, repair_valid,
                     pred_ready, err_underflow, repair_hist);
            chk({e.nm, ".spec_hist"},     32'(spec_hist),     32'(e.s));
            chk({e.nm, ".arch_hist"},     32'(arch_hist),     32'(e.a));
            chk({e.nm, ".occupancy"},     32'(occupancy),     32'(e.o));
            chk({e.nm, ".repair_valid"},  32'(repair_valid),  32'(e.rv));
            chk({e.nm, ".pred_ready"},    32'(pred_ready),    32'(e.rdy));
            chk({e.nm, ".err_underflow"}, 32'(err_underflow), 32'(e.err));
            chk({e.nm, ".repair_hist"},   32'(repair_hist),   32'(e.rh));
        end
    end

    task automatic step(input string nm, input bit pv, input bit pt, input bit rv, input bit rt,
                        input logic [11:0] es, input logic [11:0] ea, input logic [3:0] eo,
                        input bit erv, input bit erdy, input bit eerr, input logic [11:0] erh);
        exp_t x;
        @(negedge clock);
        pred_valid    = pv;
        pred_taken    = pt;
        resolve_valid = rv;
        resolve_taken = rt;
        x.nm = nm; x.c = cyc + 1; x.s = es; x.a = ea; x.o = eo;
        x.rv = erv; x.rdy = erdy; x.err = eerr; x.rh = erh;
        q.push_back(x);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".spec_hist"},     32'(spec_hist),     32'h0);
        chk({nm, ".arch_hist"},     32'(arch_hist),     32'h0);
        chk({nm, ".repair_hist"},   32'(repair_hist),   32'h0);
        chk({nm, ".repair_valid"},  32'(repair_valid),  32'h0);
        chk({nm, ".occupancy"},     32'(occupancy),     32'h0);
        chk({nm, ".err_underflow"}, 32'(err_underflow), 32'h0);
        chk({nm, ".pred_ready"},    32'(pred_ready),    32'h1);
    endtask

    // Drains pending expectations, then asserts reset mid-low-phase and checks
    // that outputs clear with no clock edge.
    task automatic do_reset(input string nm);
        int n;
        @(negedge clock);
        pred_valid = 0; pred_taken = 0; resolve_valid = 0; resolve_taken = 0;
        #1;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs(nm);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [11:0] spec_full [8];
        logic [11:0] arch_drain [7];
        int n;
        spec_full  = '{12'h800, 12'hC00, 12'hE00, 12'hF00, 12'hF80, 12'hFC0, 12'hFE0, 12'hFF0};
        arch_drain = '{12'hC00, 12'hE00, 12'hF00, 12'hF80, 12'hFC0, 12'hFE0, 12'hFF0};

        reset = 1'b1;
        pred_valid = 0; pred_taken = 0; resolve_valid = 0; resolve_taken = 0;
        #3;
        chk_reset_outputs("por");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++)
            step("idle", 0,0,0,0, 12'h000, 12'h000, 4'd0, 0, 1, 0, 12'h000);

        step("pT1", 1,1,0,0, 12'h800, 12'h000, 4'd1, 0, 1, 0, 12'h000);
        step("pT2", 1,1,0,0, 12'hC00, 12'h000, 4'd2, 0, 1, 0, 12'h000);
        step("pT3", 1,1,0,0, 12'hE00, 12'h000, 4'd3, 0, 1, 0, 12'h000);
        step("rT1", 0,0,1,1, 12'hE00, 12'h800, 4'd2, 0, 1, 0, 12'h000);
        step("rT2", 0,0,1,1, 12'hE00, 12'hC00, 4'd1, 0, 1, 0, 12'h000);
        step("rT3", 0,0,1,1, 12'hE00, 12'hE00, 4'd0, 0, 1, 0, 12'h000);
        do_reset("rst1");

        step("m_pT",  1,1,0,0, 12'h800, 12'h000, 4'd0 + 4'd1, 0, 1, 0, 12'h000);
        step("m_rT",  0,0,1,1, 12'h800, 12'h800, 4'd0, 0, 1, 0, 12'h000);
        step("m_pT2", 1,1,0,0, 12'hC00, 12'h800, 4'd1, 0, 1, 0, 12'h000);
        step("m_pT3", 1,1,0,0, 12'hE00, 12'h800, 4'd2, 0, 1, 0, 12'h000);
        step("m_rN",  0,0,1,0, 12'h400, 12'h400, 4'd0, 1, 0, 0, 12'h400);
        step("m_run", 0,0,0,0, 12'h400, 12'h400, 4'd0, 0, 1, 0, 12'h400);
        do_reset("rst2");

        for (int k = 0; k < 8; k++)
            step("fill", 1,1,0,0, spec_full[k], 12'h000, 4'(k + 1), 0, (k < 7), 0, 12'h000);
        step("p9",    1,0,0,0, 12'hFF0, 12'h000, 4'd8, 0, 0, 0, 12'h000);
        step("p9r",   1,0,1,1, 12'hFF0, 12'h800, 4'd7, 0, 1, 0, 12'h000);
        step("pwrap", 1,0,0,0, 12'h7F8, 12'h800, 4'd8, 0, 0, 0, 12'h000);
        for (int k = 0; k < 7; k++)
            step("drain", 0,0,1,1, 12'h7F8, arch_drain[k], 4'(7 - k), 0, 1, 0, 12'h000);
        step("wrapmis", 0,0,1,1, 12'hFF8, 12'hFF8, 4'd0, 1, 0, 0, 12'hFF8);
        do_reset("rst3");

        step("s_pT",   1,1,0,0, 12'h800, 12'h000, 4'd1, 0, 1, 0, 12'h000);
        step("s_rT",   0,0,1,1, 12'h800, 12'h800, 4'd0, 0, 1, 0, 12'h000);
        step("s_pN",   1,0,0,0, 12'h400, 12'h800, 4'd1, 0, 1, 0, 12'h000);
        step("s_pmis", 1,1,1,1, 12'hC00, 12'hC00, 4'd0, 1, 0, 0, 12'hC00);
        step("s_rrec", 0,0,1,1, 12'hC00, 12'hC00, 4'd0, 0, 1, 1, 12'hC00);
        step("s_pT2",  1,1,0,0, 12'hE00, 12'hC00, 4'd1, 0, 1, 1, 12'hC00);
        step("s_both", 1,0,1,1, 12'h700, 12'hE00, 4'd1, 0, 1, 1, 12'hC00);
        do_reset("rst4");

        step("u_pT", 1,1,0,0, 12'h800, 12'h000, 4'd1, 0, 1, 0, 12'h000);
        step("u_rT", 0,0,1,1, 12'h800, 12'h800, 4'd0, 0, 1, 0, 12'h000);
        step("u_uf", 0,0,1,0, 12'h800, 12'h800, 4'd0, 0, 1, 1, 12'h000);
        for (int i = 0; i < 20; i++)
            step("u_hold", 0,0,0,0, 12'h800, 12'h800, 4'd0, 0, 1, 1, 12'h000);

        step("v_pT", 1,1,0,0, 12'hC00, 12'h800, 4'd1, 0, 1, 1, 12'h000);
        step("v_rN", 0,0,1,0, 12'h400, 12'h400, 4'd0, 1, 0, 1, 12'h400);
        do_reset("rst_rec");

        step("post", 0,0,0,0, 12'h000, 12'h000, 4'd0, 0, 1, 0, 12'h000);
        @(negedge clock);
        pred_valid = 0; resolve_valid = 0;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/path_history_repair.md
Name: path_history_repair

Overview:
- Consumer and repair end of the path-history interface in the tournament branch predictor.
- Holds the speculative path history, which shifts in each fetch-time prediction. Holds the architectural (committed) path history, which shifts in each resolved outcome.
- Keeps a checkpoint FIFO of in-flight predictions. On an in-order resolve that disagrees with the prediction, restores the speculative history and signals a repair to fetch.

Parameters:
HIST_W, 12, path history width in bits
DEPTH, 8, maximum in-flight unresolved predictions (power of two)
PTR_W, 3, log2(DEPTH)

Ports:
clock  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
pred_valid  input  1  a new prediction is presented this cycle
pred_taken  input  1  predicted direction (1 = taken)
pred_ready  output  1  prediction accepted when pred_valid && pred_ready
resolve_valid  input  1  oldest in-flight branch resolves this cycle
resolve_taken  input  1  actual direction of the oldest branch
spec_hist  output  HIST_W  speculative path history
arch_hist  output  HIST_W  committed path history
repair_valid  output  1  one-cycle pulse: history repaired, fetch must redirect
repair_hist  output  HIST_W  repaired history, valid while repair_valid
occupancy  output  PTR_W+1  in-flight entry count, 0..DEPTH
err_underflow  output  1  sticky: resolve seen with occupancy 0

Behaviour:
- Reset is asynchronous, active-high, on clock. While reset is high, all of the following are cleared:
  - spec_hist, arch_hist, repair_hist = 0
  - repair_valid = 0, occupancy = 0, err_underflow = 0
  - FIFO pointers = 0, state = RUN
- All outputs are registered except pred_ready, which is decoded from registered state only.
- Shift rule, everywhere: new_hist = {bit, old_hist[HIST_W-1:1]}. The newest bit goes to the MSB; the LSB is discarded.
- State machine has two states: RUN and RECOVER.
  - pred_ready = (state == RUN) && (occupancy != DEPTH). There is no full bypass, even when a resolve pops in the same cycle.
- Accepted prediction (in RUN):
  - Push {pred_taken, spec_hist} into the FIFO. The stored history is the pre-shift value.
  - spec_hist <= shift(spec_hist, pred_taken).
  - occupancy increments.
- Resolve with occupancy > 0: pop the oldest entry {p, h}.
  - arch_hist <= shift(arch_hist, resolve_taken) always. occupancy decrements.
  - If resolve_taken == p: no other effect.
  - If resolve_taken != p (mispredict):
    - spec_hist <= shift(h, resolve_taken).
    - FIFO flushed: pointers reset, occupancy <= 0.
    - repair_hist <= shift(h, resolve_taken); repair_valid <= 1.
    - state <= RECOVER.
- RECOVER lasts exactly one cycle. During it, repair_valid = 1 and pred_ready = 0. It then returns to RUN; repair_valid drops to 0.
- Resolves are still honoured in RECOVER. The FIFO is empty there, so such a resolve takes the underflow path.
- Resolve with occupancy 0: err_underflow <= 1 (sticky until reset). arch_hist, spec_hist and the FIFO are unchanged.
- Prediction and correct resolve in the same cycle: both take effect. Push and pop are independent; occupancy is unchanged.
- Prediction and mispredicting resolve in the same cycle: the mispredict wins. The prediction is discarded (wrong path), the push is suppressed, and spec_hist takes the repaired value.
- Invariant: after a mispredict, spec_hist == arch_hist (in-order resolution). The bench checks this.
- Pointers wrap modulo DEPTH. occupancy never exceeds DEPTH.
- Reset mid-operation (e.g. during RECOVER or with a full FIFO) returns every register to its reset value immediately.

Test Plan:
- Reset, then idle 5 cycles -> spec_hist = arch_hist = 12'h000, occupancy 0, pred_ready 1, repair_valid 0, err_underflow 0.
- 3 predictions taken, then 3 resolves taken -> spec_hist 12'h800, then 12'hC00, then 12'hE00. occupancy peaks at 3. arch_hist ends at 12'hE00, occupancy 0, repair_valid never asserted.
- Mispredict repair:
  - Stimulus: predict T and resolve T (arch = spec = 12'h800); predict T (spec 12'hC00); predict T (spec 12'hE00); resolve N.
  - Response: spec_hist = arch_hist = repair_hist = 12'h400, occupancy 0, repair_valid high exactly 1 cycle, pred_ready low that cycle.
- Full FIFO:
  - 8 accepted predictions -> occupancy 8, pred_ready 0.
  - A 9th pred_valid, alone or together with a correct resolve, is not accepted: spec_hist does not shift. The resolve still takes effect (occupancy 7).
- Same-cycle pred_valid with a mispredicting resolve -> prediction dropped, occupancy 0, spec_hist == arch_hist.
- Underflow and reset:
  - resolve_valid with occupancy 0 -> err_underflow 1, arch_hist unchanged; it stays 1 for 20 further cycles.
  - Assert reset during RECOVER -> all outputs 0 asynchronously, with no clock edge needed.
